// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_pkg
// Description : Shared types and constants for the data-memory bus.
//               rd_owner_e tags which requester owns the read in flight;
//               DMEM_READ_LAT is the memory's read data latency in cycles.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_pkg;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_P0   = 2'd1,
    RD_P1   = 2'd2
  } rd_owner_e;

  localparam int DMEM_READ_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the two requester ports and the shared decode-side
//               bus. The slave modport is the arbiter's view; the master
//               modport is the view of the surrounding requesters and memory.
// Ports       : m0_* / m1_* requester handshakes, dmem_* shared bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
  logic        m0_req;
  logic [3:0]  m0_writeb;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [3:0]  m1_writeb;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [3:0]  dmem_writeb;
  logic        dmem_read;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  modport slave (
    input  m0_req, m0_writeb, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_writeb, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output dmem_writeb, dmem_read, dmem_addr, dmem_wdata,
    input  dmem_rdata
  );

  modport master (
    output m0_req, m0_writeb, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_writeb, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  dmem_writeb, dmem_read, dmem_addr, dmem_wdata,
    output dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_starve_guard.sv
`default_nettype none
// ============================================================================
// Module      : starve_guard
// Description : Fixed priority for port 0 with a bounded-starvation counter
//               that forces a port-1 grant after MAX_CONSEC consecutive
//               port-0 grants taken while port 1 was waiting.
// Ports       : clk, rst (async, active high), req0, req1 requests;
//               sel1 = port 1 wins this cycle; gnt_any = some port wins.
// Revision    : 1.0 - initial release
// ============================================================================
module starve_guard #(
  parameter int MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic sel1,
  output logic gnt_any
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_CONSEC);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic       at_max;

  always_comb begin
    at_max       = (starve_cnt_q == CNT_MAX);
    sel1         = req1 & (~req0 | at_max);
    gnt_any      = req0 | req1;
    starve_cnt_d = starve_cnt_q;
    if (sel1 || !req1) begin
      starve_cnt_d = 4'd0;
    end else if (req0 && (starve_cnt_q < CNT_MAX)) begin
      // Port 1 is waiting and lost to port 0; the cap is a safety net only,
      // since reaching CNT_MAX makes port 1 win next cycle.
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the data-memory bus between the CPU load/store unit
//               (port 0) and a secondary master (port 1). Grants at most one
//               access per cycle, drives the winner onto the decode bus and
//               steers the one-cycle-late read data back to its owner.
// Ports       : clk, rst (async, active high); bus (slave modport) carrying
//               m0_*/m1_* handshakes and the dmem_* decode bus.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import soc_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  logic       sel1;
  logic       gnt_any;
  logic       gnt0;
  logic       gnt1;
  logic [3:0] win_writeb;
  rd_owner_e  rd_owner_q;

  starve_guard #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_guard (
    .clk     (clk),
    .rst     (rst),
    .req0    (bus.m0_req),
    .req1    (bus.m1_req),
    .sel1    (sel1),
    .gnt_any (gnt_any)
  );

  always_comb begin
    gnt1       = sel1;
    gnt0       = gnt_any & ~sel1;
    win_writeb = sel1 ? bus.m1_writeb : bus.m0_writeb;

    bus.m0_gnt = gnt0;
    bus.m1_gnt = gnt1;

    // With no winner sel1 is low, so address/data idle on the port-0 inputs.
    bus.dmem_addr   = sel1 ? bus.m1_addr  : bus.m0_addr;
    bus.dmem_wdata  = sel1 ? bus.m1_wdata : bus.m0_wdata;
    bus.dmem_writeb = gnt_any ? win_writeb : 4'd0;
    bus.dmem_read   = gnt_any && (win_writeb == 4'd0);

    // Memory already registers its output, so data passes straight through.
    bus.m0_rdata  = bus.dmem_rdata;
    bus.m1_rdata  = bus.dmem_rdata;
    bus.m0_rvalid = (rd_owner_q == RD_P0);
    bus.m1_rvalid = (rd_owner_q == RD_P1);
  end

  // Return tracker: remembers who owns the read issued last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_q <= RD_NONE;
    end else if (gnt0 && (bus.m0_writeb == 4'd0)) begin
      rd_owner_q <= RD_P0;
    end else if (gnt1 && (bus.m1_writeb == 4'd0)) begin
      rd_owner_q <= RD_P1;
    end else begin
      rd_owner_q <= RD_NONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. Table of single-cycle
//               vectors plus hand-written multi-cycle sequences; read
//               returns are checked against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MAX_CONSEC = 4;

  logic clk;
  logic rst;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MAX_CONSEC (MAX_CONSEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Memory model: synchronous read, data valid one cycle after dmem_read.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1234_5678;
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (bus.dmem_read) bus.dmem_rdata <= memf(bus.dmem_addr);
  end

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t sb[$];

  // Return monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (!rst && (bus.m0_rvalid || bus.m1_rvalid)) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk("rvalid_port", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, e.port ? 32'd2 : 32'd1);
        chk("rdata", e.port ? bus.m1_rdata : bus.m0_rdata, e.data);
      end
    end
  end

  task automatic drive(input logic r0, input logic r1,
                       input logic [3:0] wb0, input logic [3:0] wb1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.m0_req = r0; bus.m0_writeb = wb0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_writeb = wb1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0, r1;
    logic [3:0]  wb0, wb1;
    logic [31:0] a0, a1, d0, d1;
    logic        eg0, eg1, erd;
    logic [3:0]  ewb;
    logic [31:0] ea, ed;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0000_0044, 32'h0000_0088, 32'h1111_1111, 32'h2222_2222,
                1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0044, 32'h1111_1111};
    vecs[1] = '{1'b1, 1'b0, 4'h0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 4'h0, 4'hF, 32'h0000_0004, 32'hFFFF_0700, 32'h0, 32'h0000_00A5,
                1'b0, 1'b1, 1'b0, 4'hF, 32'hFFFF_0700, 32'h0000_00A5};
    vecs[3] = '{1'b1, 1'b1, 4'h3, 4'h0, 32'h0000_0100, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,
                1'b1, 1'b0, 1'b0, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 4'h0, 4'h0, 32'h0000_0100, 32'h0000_0200, 32'h0, 32'h0,
                1'b0, 1'b1, 1'b1, 4'h0, 32'h0000_0200, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 4'h0, 32'h0000_0020, 32'h0000_0300, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b1, 4'h0, 32'h0000_0020, 32'h0};

    rst = 1'b1;
    bus.dmem_rdata = 32'd0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state.
    @(negedge clk);
    chk("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    chk("rst_cnt", {28'd0, dut.u_guard.starve_cnt_q}, 32'd0);
    chk("rst_gnt_rd_wb", {26'd0, bus.m0_gnt, bus.m1_gnt, bus.dmem_read, bus.dmem_writeb}, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].wb0, vecs[i].wb1,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      if (vecs[i].erd) sb.push_back('{vecs[i].eg1, memf(vecs[i].ea)});
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {30'd0, bus.m1_gnt, bus.m0_gnt}, {30'd0, vecs[i].eg1, vecs[i].eg0});
      chk($sformatf("v%0d_read", i), {31'd0, bus.dmem_read}, {31'd0, vecs[i].erd});
      chk($sformatf("v%0d_wb", i), {28'd0, bus.dmem_writeb}, {28'd0, vecs[i].ewb});
      chk($sformatf("v%0d_addr", i), bus.dmem_addr, vecs[i].ea);
      chk($sformatf("v%0d_wdata", i), bus.dmem_wdata, vecs[i].ed);
      next_cycle();
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();

    // Continuous contention: both ports write every cycle.
    begin
      logic [9:0] exp_g1;
      exp_g1 = 10'b10000_10000;  // bit i = port 1 wins in cycle i
      for (int c = 0; c < 10; c++) begin
        drive(1'b1, 1'b1, 4'hF, 4'hF, 32'h0000_1000 + c, 32'h0000_2000 + c, 32'h0, 32'h0);
        @(negedge clk);
        chk($sformatf("cont%0d_gnt", c), {30'd0, bus.m1_gnt, bus.m0_gnt},
            exp_g1[c] ? 32'd2 : 32'd1);
        if (c < 6)
          chk($sformatf("cont%0d_cnt", c), {28'd0, dut.u_guard.starve_cnt_q},
              (c < 5) ? c : 0);
        next_cycle();
      end
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();

    // Alternating reads P0, P1, P0 on consecutive cycles.
    begin
      logic [31:0] alt_a[3];
      alt_a[0] = 32'h0000_0A00; alt_a[1] = 32'h0000_0B04; alt_a[2] = 32'h0000_0C08;
      for (int k = 0; k < 3; k++) begin
        if (k == 1) drive(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, alt_a[k], 32'h0, 32'h0);
        else        drive(1'b1, 1'b0, 4'h0, 4'h0, alt_a[k], 32'h0, 32'h0, 32'h0);
        sb.push_back('{(k == 1), memf(alt_a[k])});
        @(negedge clk);
        chk($sformatf("alt%0d_gnt", k), {30'd0, bus.m1_gnt, bus.m0_gnt}, (k == 1) ? 32'd2 : 32'd1);
        next_cycle();
      end
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();

    // Reset asserted the cycle after a port-1 read grant drops the return.
    drive(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0000_0300, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstmid_gnt1", {31'd0, bus.m1_gnt}, 32'd1);
    next_cycle();
    chk("rstmid_pending", {31'd0, bus.m1_rvalid}, 32'd1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0000_0300, 32'h0, 32'h0);
    #1;
    chk("rstmid_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
    chk("rstmid_cnt", {28'd0, dut.u_guard.starve_cnt_q}, 32'd0);
    next_cycle();
    chk("rstmid_cnt_held", {28'd0, dut.u_guard.starve_cnt_q}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();

    // No requests for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", c),
          {24'd0, bus.m0_rvalid, bus.m1_rvalid, bus.m0_gnt, bus.m1_gnt, bus.dmem_read, bus.dmem_writeb[2:0]}
          | {28'd0, bus.dmem_writeb[3], 3'd0}, 32'd0);
      next_cycle();
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
